decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Parametrised, handshaked successor to the LC-3b decode stage: holds the register file and CC register, plus a per-register pending-write scoreboard.
- Stalls the front end on RAW hazards and registers the decoded operands into a valid/ready output buffer feeding execute.
- Sits between fetch (upstream valid/ready) and execute (downstream valid/ready); write-back returns on a dedicated port.

Parameters:
WIDTH, 16, data width of registers, npc, ir and operands
PEND_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^PEND_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_npc  in  WIDTH  next PC of instruction
in_ir  in  WIDTH  instruction word
in_uses_a  in  1  instruction reads SR1 = ir[8:6]
in_uses_b  in  1  instruction reads SR2
in_b_sel  in  1  SR2 index: 0 = ir[11:9], 1 = ir[2:0]
in_writes  in  1  instruction writes a destination register
in_dest_sel  in  1  DR index: 0 = ir[11:9], 1 = 3'b111
out_valid  out  1  output buffer holds an instruction
out_ready  in  1  execute consumes output this cycle
out_npc  out  WIDTH  registered npc
out_ir  out  WIDTH  registered ir
out_sr1  out  WIDTH  SR1 operand value
out_sr2  out  WIDTH  SR2 operand value
out_dr  out  3  destination index
out_writes  out  1  registered in_writes
wb_en  in  1  write-back valid
wb_dest  in  3  write-back register index
wb_data  in  WIDTH  write-back data
wb_cc_en  in  1  load CC
wb_cc  in  3  NZP value
cc_out  out  3  current CC

Clock/reset (already decided): one clock, clk; reset rst_n, asynchronous, active-low.

Behaviour:
- Reset: all 8 registers = 0, all pending counters = 0, cc_out = 3'b010, out_valid = 0, all out_* fields = 0.
- Register file: 8 x WIDTH, written on the clk edge when wb_en. Reads are combinational and return the pre-write value in the write cycle.
- Hazard on A: in_uses_a and pend[ir[8:6]] != 0. Hazard on B: same test on the selected SR2 index.
- Structural stall: in_writes and pend[DR] == 2^PEND_W-1.
- in_ready = no hazard, no structural stall, and (!out_valid or out_ready). It is combinational and depends on in_* fields even when in_valid = 0.
- Accept = in_valid & in_ready. On accept:
  - the output buffer loads npc, ir, operand values, DR and writes; out_valid = 1 next cycle.
  - if in_writes, pend[DR] increments.
- Output handshake:
  - out_valid & out_ready without accept: out_valid clears.
  - out_valid & !out_ready: all out_* are held stable.
  - Accept and out_ready in the same cycle: back-to-back, out_valid stays 1.
- Retire: wb_en decrements pend[wb_dest] if nonzero. A write-back to a register with pend == 0 updates the register file but leaves the counter at 0 (no underflow).
- Simultaneous increment and decrement of the same register: counter unchanged.
- Latency: 1 cycle from accept to out_valid. With no bypass, a dependent instruction is accepted no earlier than the cycle after the producer's wb_en.
- CC: cc_out loads wb_cc on the clk edge when wb_cc_en; cc_out is not scoreboarded.
- Reset mid-operation: asynchronous; clears all state, including pending counters and the output buffer, regardless of in-flight handshakes.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- When defined:
  - a hazard on A or B is waived if wb_en, wb_dest equals that source index, and pend[index] == 1.
  - the operand captured on accept is wb_data instead of the regfile value; both operands bypass independently.
  - a dependent instruction is accepted in the producer's wb_en cycle.
- When undefined: no waiver, no forwarding mux; behaviour is exactly as in Behaviour.

Test Plan:
- Reset release, then write-back R3=0x1234, then accept ADD R1,R3,R2 (uses_a, uses_b, b_sel=1, writes) -> next cycle out_valid=1, out_sr1=0x1234, out_dr=1, pend[1]=1.
- With pend[1]=1, present an instruction reading R1 -> in_ready=0. Without bypass: wb_en R1=0x00FF; accept the cycle after; out_sr1=0x00FF. With DECODE_WB_BYPASS_EN: accept in the wb_en cycle; out_sr1=0x00FF.
- Three back-to-back writers of R7 (dest_sel=1), PEND_W=2, no write-backs -> first three accepted, pend[7]=3; a fourth writer of R7 stalls until a wb_en to R7.
- Hold out_ready=0 with a second instruction pending -> out_* held unchanged and in_ready=0. Raise out_ready -> second instruction loads next cycle, out_valid stays 1.
- wb_en to R5 with pend[5]=0 -> regfile R5 updated, pend[5] stays 0. Same cycle, accept a writer of R2 while wb_en R2 arrives with pend[2]=1 -> pend[2] stays 1.
- Assert rst_n=0 asynchronously with out_valid=1 and pend[4]=2 -> out_valid=0, pend[4]=0 and cc_out=3'b010 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_if
// Description : Bundle of the decode/issue stage handshakes: the fetch-side
//               instruction channel (in_*), the execute-side output buffer
//               (out_*), the write-back return port (wb_*) and the CC output.
//               slave  : the decode/issue stage itself
//               master : the surrounding fetch / execute / write-back logic
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_issue_if #(
    parameter int WIDTH = 16
);
    // Fetch -> decode
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_npc;
    logic [WIDTH-1:0] in_ir;
    logic             in_uses_a;
    logic             in_uses_b;
    logic             in_b_sel;
    logic             in_writes;
    logic             in_dest_sel;
    // Decode -> execute
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_npc;
    logic [WIDTH-1:0] out_ir;
    logic [WIDTH-1:0] out_sr1;
    logic [WIDTH-1:0] out_sr2;
    logic [2:0]       out_dr;
    logic             out_writes;
    // Write-back -> decode
    logic             wb_en;
    logic [2:0]       wb_dest;
    logic [WIDTH-1:0] wb_data;
    logic             wb_cc_en;
    logic [2:0]       wb_cc;
    logic [2:0]       cc_out;

    modport slave (
        input  in_valid, in_npc, in_ir, in_uses_a, in_uses_b, in_b_sel,
               in_writes, in_dest_sel, out_ready,
               wb_en, wb_dest, wb_data, wb_cc_en, wb_cc,
        output in_ready, out_valid, out_npc, out_ir, out_sr1, out_sr2,
               out_dr, out_writes, cc_out
    );

    modport master (
        output in_valid, in_npc, in_ir, in_uses_a, in_uses_b, in_b_sel,
               in_writes, in_dest_sel, out_ready,
               wb_en, wb_dest, wb_data, wb_cc_en, wb_cc,
        input  in_ready, out_valid, out_npc, out_ir, out_sr1, out_sr2,
               out_dr, out_writes, cc_out
    );
endinterface
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_stage
// Description : LC-3b style decode/issue stage. Holds the 8-entry register
//               file, the CC register and a per-register pending-write
//               scoreboard. Stalls fetch on RAW hazards or a saturated
//               scoreboard counter and registers the decoded operands into a
//               valid/ready output buffer feeding execute.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - decode_issue_if.slave (fetch in_*, execute out_*,
//                       write-back wb_*, cc_out)
// Options     : DECODE_WB_BYPASS_EN - when defined, a source whose only
//               outstanding write is retiring this cycle is forwarded from
//               wb_data instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_stage #(
    parameter int WIDTH  = 16,
    parameter int PEND_W = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_issue_if.slave bus
);
    localparam logic [PEND_W-1:0] c_PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] c_PEND_ONE = PEND_W'(1);
    localparam logic [2:0]        c_CC_RESET = 3'b010;

    logic [WIDTH-1:0]  r_rf   [8];
    logic [PEND_W-1:0] r_pend [8];
    logic [2:0]        r_cc;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_npc;
    logic [WIDTH-1:0]  r_out_ir;
    logic [WIDTH-1:0]  r_out_sr1;
    logic [WIDTH-1:0]  r_out_sr2;
    logic [2:0]        r_out_dr;
    logic              r_out_writes;

    logic [2:0]        w_sr1_idx;
    logic [2:0]        w_sr2_idx;
    logic [2:0]        w_dr_idx;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_full;
    logic              w_in_ready;
    logic              w_accept;
    logic [WIDTH-1:0]  w_op_a;
    logic [WIDTH-1:0]  w_op_b;
    logic [7:0]        w_inc;
    logic [7:0]        w_dec;

    assign w_sr1_idx = bus.in_ir[8:6];
    assign w_sr2_idx = bus.in_b_sel    ? bus.in_ir[2:0] : bus.in_ir[11:9];
    assign w_dr_idx  = bus.in_dest_sel ? 3'b111         : bus.in_ir[11:9];

`ifdef DECODE_WB_BYPASS_EN
    // A source is safe to read this cycle when its last outstanding write is
    // the one retiring right now; the value comes straight from wb_data.
    logic w_byp_a;
    logic w_byp_b;
    assign w_byp_a = bus.wb_en && (bus.wb_dest == w_sr1_idx) && (r_pend[w_sr1_idx] == c_PEND_ONE);
    assign w_byp_b = bus.wb_en && (bus.wb_dest == w_sr2_idx) && (r_pend[w_sr2_idx] == c_PEND_ONE);
    assign w_haz_a = bus.in_uses_a && (r_pend[w_sr1_idx] != '0) && !w_byp_a;
    assign w_haz_b = bus.in_uses_b && (r_pend[w_sr2_idx] != '0) && !w_byp_b;
    assign w_op_a  = w_byp_a ? bus.wb_data : r_rf[w_sr1_idx];
    assign w_op_b  = w_byp_b ? bus.wb_data : r_rf[w_sr2_idx];
`else
    assign w_haz_a = bus.in_uses_a && (r_pend[w_sr1_idx] != '0);
    assign w_haz_b = bus.in_uses_b && (r_pend[w_sr2_idx] != '0);
    // Register file reads return the pre-write value during a write-back.
    assign w_op_a  = r_rf[w_sr1_idx];
    assign w_op_b  = r_rf[w_sr2_idx];
`endif

    // A saturated counter cannot track another in-flight write; the stall
    // holds even if that register is retiring this cycle.
    assign w_full     = bus.in_writes && (r_pend[w_dr_idx] == c_PEND_MAX);
    assign w_in_ready = !w_haz_a && !w_haz_b && !w_full && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < 8; i++) begin
            w_inc[i] = w_accept && bus.in_writes && (w_dr_idx == 3'(i));
            // Retiring an untracked write leaves the counter at zero.
            w_dec[i] = bus.wb_en && (bus.wb_dest == 3'(i)) && (r_pend[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i]   <= '0;
                r_pend[i] <= '0;
            end
            r_cc <= c_CC_RESET;
        end else begin
            if (bus.wb_en) begin
                r_rf[bus.wb_dest] <= bus.wb_data;
            end
            if (bus.wb_cc_en) begin
                r_cc <= bus.wb_cc;
            end
            for (int i = 0; i < 8; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + c_PEND_ONE;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_pend[i] <= r_pend[i] - c_PEND_ONE;
                end
            end
        end
    end

    // Output buffer: loads on accept (also covers back-to-back when execute
    // drains in the same cycle); fields are untouched while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_npc    <= '0;
            r_out_ir     <= '0;
            r_out_sr1    <= '0;
            r_out_sr2    <= '0;
            r_out_dr     <= '0;
            r_out_writes <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_npc    <= bus.in_npc;
            r_out_ir     <= bus.in_ir;
            r_out_sr1    <= w_op_a;
            r_out_sr2    <= w_op_b;
            r_out_dr     <= w_dr_idx;
            r_out_writes <= bus.in_writes;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_npc    = r_out_npc;
    assign bus.out_ir     = r_out_ir;
    assign bus.out_sr1    = r_out_sr1;
    assign bus.out_sr2    = r_out_sr2;
    assign bus.out_dr     = r_out_dr;
    assign bus.out_writes = r_out_writes;
    assign bus.cc_out     = r_cc;
endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`timescale 1ns/1ps
module tb_decode_issue_stage;
    localparam int WIDTH  = 16;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_issue_if #(.WIDTH(WIDTH)) bus ();

    decode_issue_stage #(.WIDTH(WIDTH), .PEND_W(PEND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays/integers.
    logic [15:0] m_rf [8];
    int          m_pend [8];
    logic [2:0]  m_cc;
    logic        m_ov;
    logic [15:0] m_npc, m_ir, m_sr1, m_sr2;
    logic [2:0]  m_dr;
    logic        m_wr;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 0;
        end
        m_cc = 3'b010; m_ov = 0; m_npc = 0; m_ir = 0; m_sr1 = 0; m_sr2 = 0; m_dr = 0; m_wr = 0;
    endtask

    function automatic int src_a();
        return int'(bus.in_ir[8:6]);
    endfunction
    function automatic int src_b();
        return bus.in_b_sel ? int'(bus.in_ir[2:0]) : int'(bus.in_ir[11:9]);
    endfunction
    function automatic int dest();
        return bus.in_dest_sel ? 7 : int'(bus.in_ir[11:9]);
    endfunction
    function automatic bit waived(int idx);
`ifdef DECODE_WB_BYPASS_EN
        return bus.wb_en && (int'(bus.wb_dest) == idx) && (m_pend[idx] == 1);
`else
        return (idx < 0);
`endif
    endfunction
    function automatic bit model_ready();
        bit haz_a, haz_b, full;
        haz_a = bus.in_uses_a && (m_pend[src_a()] > 0) && !waived(src_a());
        haz_b = bus.in_uses_b && (m_pend[src_b()] > 0) && !waived(src_b());
        full  = bus.in_writes && (m_pend[dest()] == PMAX);
        return !haz_a && !haz_b && !full && (!m_ov || bus.out_ready);
    endfunction
    function automatic logic [15:0] operand(int idx);
        return waived(idx) ? bus.wb_data : m_rf[idx];
    endfunction

    function automatic logic [71:0] model_out();
        return {m_ov, m_npc, m_ir, m_sr1, m_sr2, m_dr, m_wr, m_cc};
    endfunction
    function automatic logic [71:0] dut_out();
        return {bus.out_valid, bus.out_npc, bus.out_ir, bus.out_sr1, bus.out_sr2,
                bus.out_dr, bus.out_writes, bus.cc_out};
    endfunction

    // Advance one clock: sample inputs at the falling edge, apply the
    // specified next-state rules, land at posedge+1.
    task automatic tick();
        bit acc, wbe, cce, ordy, wr;
        int d, wd;
        logic [15:0] a, b, wdat, npc, ir;
        logic [2:0] cc;
        int n_pend [8];
        @(negedge clk);
        acc  = bus.in_valid && model_ready();
        d    = dest();
        a    = operand(src_a());
        b    = operand(src_b());
        wbe  = bus.wb_en; wd = int'(bus.wb_dest); wdat = bus.wb_data;
        cce  = bus.wb_cc_en; cc = bus.wb_cc; ordy = bus.out_ready;
        npc  = bus.in_npc; ir = bus.in_ir; wr = bus.in_writes;
        n_pend = m_pend;
        if (acc && wr) n_pend[d] = n_pend[d] + 1;
        if (wbe && m_pend[wd] > 0) n_pend[wd] = n_pend[wd] - 1;
        @(posedge clk);
        #1;
        m_pend = n_pend;
        if (wbe) m_rf[wd] = wdat;
        if (cce) m_cc = cc;
        if (acc) begin
            m_ov = 1; m_npc = npc; m_ir = ir; m_sr1 = a; m_sr2 = b; m_dr = 3'(d); m_wr = wr;
        end else if (ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_npc = 0; bus.in_ir = 0; bus.in_uses_a = 0; bus.in_uses_b = 0;
        bus.in_b_sel = 0; bus.in_writes = 0; bus.in_dest_sel = 0;
        bus.wb_en = 0; bus.wb_dest = 0; bus.wb_data = 0; bus.wb_cc_en = 0; bus.wb_cc = 0;
    endtask

    task automatic set_instr(logic [15:0] npc, logic [15:0] ir, bit ua, bit ub, bit bsel, bit wr, bit dsel);
        bus.in_valid = 1; bus.in_npc = npc; bus.in_ir = ir; bus.in_uses_a = ua; bus.in_uses_b = ub;
        bus.in_b_sel = bsel; bus.in_writes = wr; bus.in_dest_sel = dsel;
    endtask

    task automatic set_wb(bit en, logic [2:0] d, logic [15:0] data);
        bus.wb_en = en; bus.wb_dest = d; bus.wb_data = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1;
        model_reset();
        #12;
        if (dut_out() !== model_out()) begin
            errors++; $display("FAIL reset_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
        if (bus.cc_out !== 3'b010) begin
            errors++; $display("FAIL reset_cc: got %b exp 010", bus.cc_out);
        end
        checks++;
        rst_n = 1;
        @(posedge clk); #1;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b exp 1", bus.in_ready);
        end
        checks++;
    endtask

    task automatic test_add();
        set_wb(1, 3'd3, 16'h1234);
        tick();
        set_wb(0, 0, 0);
        // ADD R1,R3,R2
        set_instr(16'h3002, 16'h12C2, 1, 1, 1, 1, 0);
        #1;
        if (bus.in_ready !== model_ready() || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL add_ready: got %b exp %b", bus.in_ready, model_ready());
        end
        checks++;
        tick();
        bus.in_valid = 0;
        #1;
        if (dut_out() !== model_out()) begin
            errors++; $display("FAIL add_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sr1 !== 16'h1234 || bus.out_dr !== 3'd1) begin
            errors++; $display("FAIL add_fields: got v=%b sr1=%h dr=%0d exp v=1 sr1=1234 dr=1",
                               bus.out_valid, bus.out_sr1, bus.out_dr);
        end
        checks++;
    endtask

    task automatic test_raw();
        // ADD R4,R1,#0 reads R1, which has one write in flight
        set_instr(16'h3004, 16'h1860, 1, 0, 0, 0, 0);
        #1;
        if (bus.in_ready !== 1'b0 || model_ready() !== 1'b0) begin
            errors++; $display("FAIL raw_stall: got %b exp 0", bus.in_ready);
        end
        checks++;
        tick();
        set_wb(1, 3'd1, 16'h00FF);
        #1;
        if (bus.in_ready !== model_ready()) begin
            errors++; $display("FAIL raw_wb_cycle: got %b exp %b", bus.in_ready, model_ready());
        end
        checks++;
        tick();
        set_wb(0, 0, 0);
        #1;
        if (bus.in_ready !== model_ready() || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL raw_after_wb: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        bus.in_valid = 0;
        #1;
        if (dut_out() !== model_out() || bus.out_sr1 !== 16'h00FF) begin
            errors++; $display("FAIL raw_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
    endtask

    task automatic test_structural();
        for (int k = 0; k < 4; k++) begin
            set_instr(16'h4000 + 16'(k), 16'h0E00 | 16'(k), 0, 0, 0, 1, 1);
            #1;
            if (bus.in_ready !== model_ready() || bus.in_ready !== (k < 3)) begin
                errors++; $display("FAIL struct_writer%0d: got %b exp %b", k, bus.in_ready, k < 3);
            end
            checks++;
            if (k < 3) tick();
        end
        set_wb(1, 3'd7, 16'h7777);
        #1;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL struct_wb_cycle: got %b exp 0", bus.in_ready);
        end
        checks++;
        tick();
        set_wb(0, 0, 0);
        #1;
        if (bus.in_ready !== model_ready() || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL struct_release: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        bus.in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            set_wb(1, 3'd7, 16'h7000 + 16'(k));
            tick();
        end
        set_wb(0, 0, 0);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1;
        set_instr(16'h0100, 16'h5000, 0, 0, 0, 0, 0);
        tick();
        bus.out_ready = 0;
        set_instr(16'h0200, 16'h6000, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (bus.in_ready !== 1'b0 || dut_out() !== model_out() || bus.out_npc !== 16'h0100) begin
                errors++; $display("FAIL hold_%0d: got rdy=%b out=%h exp rdy=0 out=%h",
                                   k, bus.in_ready, dut_out(), model_out());
            end
            checks++;
            tick();
        end
        bus.out_ready = 1;
        #1;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        bus.in_valid = 0;
        #1;
        if (dut_out() !== model_out() || bus.out_valid !== 1'b1 || bus.out_npc !== 16'h0200) begin
            errors++; $display("FAIL b2b_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
    endtask

    task automatic test_pend_edges();
        bus.out_ready = 1;
        set_wb(1, 3'd5, 16'hBEEF);
        tick();
        set_wb(0, 0, 0);
        set_instr(16'h0300, 16'h1140, 1, 0, 0, 0, 0);   // reads R5
        #1;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL underflow_ready: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        bus.in_valid = 0;
        #1;
        if (dut_out() !== model_out() || bus.out_sr1 !== 16'hBEEF) begin
            errors++; $display("FAIL underflow_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
        set_instr(16'h0400, 16'h1400, 0, 0, 0, 1, 0);   // writes R2
        tick();
        set_instr(16'h0402, 16'h1401, 0, 0, 0, 1, 0);   // writes R2 again
        set_wb(1, 3'd2, 16'h2222);
        #1;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL incdec_ready: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        set_wb(0, 0, 0);
        set_instr(16'h0404, 16'h1080, 1, 0, 0, 0, 0);   // reads R2
        #1;
        if (bus.in_ready !== 1'b0 || model_ready() !== 1'b0) begin
            errors++; $display("FAIL incdec_pend: got %b exp 0", bus.in_ready);
        end
        checks++;
        set_wb(1, 3'd2, 16'h2323);
        tick();
        set_wb(0, 0, 0);
        #1;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL incdec_drain: got %b exp 1", bus.in_ready);
        end
        checks++;
        tick();
        bus.in_valid = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_instr(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()),
                      1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.wb_en     = ($urandom_range(0, 1) == 1);
            bus.wb_dest   = 3'($urandom());
            if ($urandom_range(0, 3) != 0) begin
                int s = $urandom_range(0, 7);
                for (int j = 0; j < 8; j++) begin
                    if (m_pend[(s + j) % 8] > 0) begin
                        bus.wb_dest = 3'((s + j) % 8);
                        break;
                    end
                end
            end
            bus.wb_data  = 16'($urandom());
            bus.wb_cc_en = ($urandom_range(0, 3) == 0);
            bus.wb_cc    = 3'($urandom());
            #1;
            if (bus.in_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready@%0d: got %b exp %b", n, bus.in_ready, model_ready());
            end
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL rand_out@%0d: got %h exp %h", n, dut_out(), model_out());
            end
            checks++;
            tick();
        end
        idle_inputs();
        bus.out_ready = 1;
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < PMAX && m_pend[r] > 0; k++) begin
                set_wb(1, 3'(r), 16'h0A00 + 16'(r));
                tick();
            end
        end
        set_wb(0, 0, 0);
        bus.wb_cc_en = 1; bus.wb_cc = 3'b101;
        set_instr(16'h0500, 16'h1800, 0, 0, 0, 1, 0);   // writes R4
        tick();
        bus.wb_cc_en = 0;
        set_instr(16'h0502, 16'h1801, 0, 0, 0, 1, 0);   // writes R4
        tick();
        bus.out_ready = 0;
        set_instr(16'h0504, 16'h1100, 1, 0, 0, 0, 0);   // reads R4
        #1;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.cc_out !== 3'b101) begin
            errors++; $display("FAIL prereset: got v=%b rdy=%b cc=%b exp v=1 rdy=0 cc=101",
                               bus.out_valid, bus.in_ready, bus.cc_out);
        end
        checks++;
        #1;
        rst_n = 0;
        model_reset();
        #1;
        if (dut_out() !== model_out() || bus.cc_out !== 3'b010) begin
            errors++; $display("FAIL async_reset_out: got %h exp %h", dut_out(), model_out());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_pend: got %b exp 1", bus.in_ready);
        end
        checks++;
        @(posedge clk); #1;
        rst_n = 1;
        bus.in_valid = 0;
        bus.out_ready = 1;
        #1;
        if (dut_out() !== model_out()) begin
            errors++; $display("FAIL post_reset: got %h exp %h", dut_out(), model_out());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_raw();
        test_structural();
        test_backpressure();
        test_pend_edges();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
